// File: rtl/pow3_unit.sv
// Sequential cube calculator: y = a^3 using one shift-add multiplier, run
// first for a*a and then for (a*a)*a; start/busy handshake, held result.
module pow3_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  a_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [23:0] y_bo
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2} state_t;

  state_t      state;
  logic [7:0]  a_reg;
  logic [2:0]  cnt;
  logic [23:0] acc;
  logic [15:0] sq;

  logic [23:0] operand;
  logic [23:0] addend;
  logic [23:0] sum;

  // The single shared adder: multiplicand is a during squaring, the square during cubing.
  always_comb begin
    operand = (state == MUL2) ? {8'd0, sq} : {16'd0, a_reg};
    addend  = 24'd0;
    if (a_reg[cnt])
      addend = operand << cnt;
    sum = acc + addend;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      a_reg  <= 8'd0;
      cnt    <= 3'd0;
      acc    <= 24'd0;
      sq     <= 16'd0;
      busy_o <= 1'b0;
      y_bo   <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_reg  <= a_bi;
            acc    <= 24'd0;
            cnt    <= 3'd0;
            busy_o <= 1'b1;
            state  <= MUL1;
          end
        end
        MUL1: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            sq    <= sum[15:0];
            acc   <= 24'd0;
            state <= MUL2;
          end else begin
            acc <= sum;
          end
        end
        MUL2: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            y_bo   <= sum;
            acc    <= 24'd0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= sum;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pow3_unit.sv
// Directed self-checking bench for pow3_unit: reset, latency, boundaries,
// busy interference, mid-operation reset and back-to-back runs.
module tb_pow3_unit;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  a_bi;
  logic        start_i;
  logic        busy_o;
  logic [23:0] y_bo;

  int checks;
  int errors;

  pow3_unit dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_bi   (a_bi),
    .start_i(start_i),
    .busy_o (busy_o),
    .y_bo   (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d (0x%06h) expected=%0d (0x%06h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Pulse start for one cycle and verify busy holds for exactly 16 edges before the result lands.
  task automatic run_and_check(input string tag, input logic [7:0] a, input logic [23:0] prev,
                               input logic [23:0] exp);
    int high_cnt;
    a_bi    = a;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check({tag, "_busy_e0"}, {23'd0, busy_o}, 24'd1);
    check({tag, "_y_hold"}, y_bo, prev);
    high_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      if (busy_o) high_cnt++;
    end
    check({tag, "_busy_cycles"}, 24'(high_cnt), 24'd15);
    tick(1);
    check({tag, "_busy_done"}, {23'd0, busy_o}, 24'd0);
    check({tag, "_y"}, y_bo, exp);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_bi    = 8'd0;

    tick(2);
    check("reset_busy", {23'd0, busy_o}, 24'd0);
    check("reset_y", y_bo, 24'd0);
    rst_i = 1'b1;
    tick(2);
    check("release_busy", {23'd0, busy_o}, 24'd0);
    check("release_y", y_bo, 24'd0);

    run_and_check("basic8", 8'd8, 24'd0, 24'd512);
    run_and_check("zero", 8'd0, 24'd512, 24'd0);
    run_and_check("one", 8'd1, 24'd0, 24'd1);
    run_and_check("max255", 8'd255, 24'd1, 24'hFD02FF);

    // Start with a=3, then poke start with a different operand while busy.
    a_bi    = 8'd3;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(5);
    a_bi    = 8'd200;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check("interf_busy_mid", {23'd0, busy_o}, 24'd1);
    check("interf_y_hold", y_bo, 24'hFD02FF);
    tick(9);
    check("interf_busy_e15", {23'd0, busy_o}, 24'd1);
    tick(1);
    check("interf_busy_done", {23'd0, busy_o}, 24'd0);
    check("interf_y", y_bo, 24'd27);
    tick(3);
    check("interf_no_rerun", {23'd0, busy_o}, 24'd0);
    check("interf_y_kept", y_bo, 24'd27);

    // Abort a run mid-way; reset must clear outputs without waiting for a clock.
    a_bi    = 8'd10;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(7);
    rst_i = 1'b0;
    #1;
    check("midrst_busy", {23'd0, busy_o}, 24'd0);
    check("midrst_y", y_bo, 24'd0);
    tick(2);
    rst_i = 1'b1;
    tick(1);
    check("midrst_after_busy", {23'd0, busy_o}, 24'd0);
    run_and_check("after_rst5", 8'd5, 24'd0, 24'd125);

    // Held start: one idle cycle between consecutive runs.
    a_bi    = 8'd2;
    start_i = 1'b1;
    tick(1);
    check("b2b_busy_e0", {23'd0, busy_o}, 24'd1);
    tick(15);
    check("b2b_busy_e15", {23'd0, busy_o}, 24'd1);
    tick(1);
    check("b2b_gap_busy", {23'd0, busy_o}, 24'd0);
    check("b2b_y1", y_bo, 24'd8);
    tick(1);
    check("b2b_restart_busy", {23'd0, busy_o}, 24'd1);
    start_i = 1'b0;
    tick(15);
    check("b2b_second_busy", {23'd0, busy_o}, 24'd1);
    check("b2b_second_y_hold", y_bo, 24'd8);
    tick(1);
    check("b2b_second_done", {23'd0, busy_o}, 24'd0);
    check("b2b_y2", y_bo, 24'd8);
    tick(2);
    check("b2b_idle", {23'd0, busy_o}, 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
